wb_rsp_fifo: RTL and testbench
==============================

# wb_rsp_fifo

Response buffer between the Wishbone bus master's return channel and the UART response coder. It captures each 34-bit response word strobed out by the master, which has no backpressure of its own. It holds the words in a first-in first-out buffer and presents them one at a time to the coder using a valid/busy handshake. It raises an almost-full flag so command intake can be paused before any response is lost, and records any loss in a sticky overflow flag.

## Interface
Parameters:
- DW, 34, response word width (2-bit tag + 32-bit payload).
- LGFLEN, 4, log2 of capacity; capacity DEPTH = 2^LGFLEN words, minimum LGFLEN = 2.

Ports:
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_stb  in  1  write strobe from the master's response channel; one word per high cycle.
- i_word  in  DW  response word; sampled when i_stb = 1.
- i_busy  in  1  coder busy; a word is consumed in any cycle with o_stb = 1 and i_busy = 0.
- o_stb  out  1  o_word is valid.
- o_word  out  DW  oldest stored word.
- o_fill  out  LGFLEN+1  number of stored words, including the one on o_word; range 0..DEPTH.
- o_full  out  1  o_fill == DEPTH.
- o_almost_full  out  1  o_fill >= DEPTH-2; drives the master's command-busy input.
- o_overflow  out  1  sticky; set when a write is dropped.
- i_clr_overflow  in  1  clears o_overflow.

## Operation
- Storage is a circular buffer with a write pointer, a read pointer, and a fill counter.
  - Pointers are LGFLEN bits wide and wrap modulo DEPTH.
  - o_fill is LGFLEN+1 bits wide, so DEPTH is representable.
- Output stage is a registered holding slot. The word in the slot is the oldest word and is counted in o_fill.
- Define push = i_stb and accepted. Define pop = o_stb and !i_busy.
- Write acceptance:
  - o_full = 0: the write is accepted.
  - o_full = 1 and pop in the same cycle: the write is accepted and o_fill is unchanged.
  - o_full = 1 and no pop: the word is dropped, o_overflow is set, and no state other than o_overflow changes.
- Fill update: o_fill next = o_fill + push − pop.
- Output stage refill:
  - On pop, the slot reloads from the read pointer if more words remain; otherwise o_stb goes to 0.
  - Write into an empty buffer (o_fill = 0): the word bypasses storage and loads the slot directly.
  - When o_fill = 1 and a push and pop occur together, the pushed word loads the slot.
- Order is strictly first-in first-out. No word is duplicated, reordered, or skipped.
- o_word holds its value while o_stb = 1 and i_busy = 1. o_word is don't-care when o_stb = 0.
- o_overflow:
  - Set by a dropped write.
  - Cleared by i_clr_overflow.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset (asynchronous, may arrive mid-operation):
  - All contents are discarded and the pointers return to 0.
  - Outputs on reset: o_stb = 0, o_word = 0, o_fill = 0, o_full = 0, o_almost_full = 0, o_overflow = 0.
  - Normal operation resumes on the first clock edge after i_reset is released.

## Timing
- Write-to-valid latency is 1 cycle: i_stb sampled at edge k into an empty buffer gives o_stb = 1 and o_word = i_word after edge k.
- Consume-to-next latency is 1 cycle: a pop at edge k presents the next word (if any) after edge k. With i_busy held at 0, throughput is one word per cycle.
- o_fill, o_full, o_almost_full and o_overflow are all registered and reflect the state after each edge.
- o_almost_full provides 2 words of margin for responses already in flight from the master.
- No combinational path exists from i_busy or i_stb to any output.

## Test plan
- Reset then single word: i_word = 0x2_DEADBEEF strobed 1 cycle with i_busy = 0 → next cycle o_stb = 1 and o_word = 0x2_DEADBEEF; the following cycle o_stb = 0 and o_fill = 0.
- Fill to capacity: i_busy = 1, 16 writes of values 0..15 → o_fill = 16, o_full = 1, o_almost_full from fill 14. Then a 17th write of 0x3_FFFFFFFF → dropped, o_overflow = 1, o_fill = 16. Then i_busy = 0 → values 0..15 emerge in order, 1 per cycle.
- Full with simultaneous push and pop: o_fill = 16, write 0x1_12345678 in the pop cycle → o_overflow stays 0, o_fill stays 16, and the word appears last after draining.
- Backpressure stall: o_stb = 1, i_busy toggled 1,1,0 → o_word is stable for 3 cycles and advances only after the i_busy = 0 cycle.
- Wrap-around: 40 words streamed with random i_busy → output sequence equals input sequence, and o_fill never exceeds 16.
- Overflow precedence and reset: i_clr_overflow and a dropped write in the same cycle → o_overflow = 1. Asynchronous i_reset pulse while o_fill = 5 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_rsp_fifo.sv
// Response buffer between the Wishbone master return channel and the UART coder.
// The memory holds every stored word; the output slot is a registered copy of mem[rptr].
module wb_rsp_fifo #(
    parameter int DW     = 34,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [DW-1:0]     i_word,
    input  logic              i_busy,
    output logic              o_stb,
    output logic [DW-1:0]     o_word,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_LVL   = (LGFLEN+1)'(DEPTH);
    localparam logic [LGFLEN:0] ALMOST_LVL = (LGFLEN+1)'(DEPTH - 2);
    localparam logic [LGFLEN:0] ONE        = (LGFLEN+1)'(1);
    localparam logic [LGFLEN:0] ZERO       = '0;

    logic [DW-1:0]     mem [DEPTH];
    logic [LGFLEN-1:0] wptr, rptr, rnext;
    logic              push, pop;
    logic [LGFLEN:0]   fill_next;

    assign pop   = o_stb && !i_busy;
    // A full buffer still accepts a write when the slot drains in the same cycle.
    assign push  = i_stb && (!o_full || pop);
    assign rnext = rptr + 1'b1;

    always_comb begin
        fill_next = o_fill;
        if (push && !pop)
            fill_next = o_fill + ONE;
        else if (!push && pop)
            fill_next = o_fill - ONE;
    end

    // Storage is not reset; pointers and fill define what is valid.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wptr] <= i_word;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr          <= '0;
            rptr          <= '0;
            o_fill        <= '0;
            o_stb         <= 1'b0;
            o_word        <= '0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rnext;
            o_fill        <= fill_next;
            o_stb         <= (fill_next != ZERO);
            o_full        <= (fill_next == FULL_LVL);
            o_almost_full <= (fill_next >= ALMOST_LVL);
            // With one word left, a simultaneous push must feed the slot directly.
            if (pop) begin
                if (o_fill > ONE)
                    o_word <= mem[rnext];
                else if (push)
                    o_word <= i_word;
            end else if (push && o_fill == ZERO) begin
                o_word <= i_word;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_overflow <= 1'b0;
        else if (i_stb && !push)
            o_overflow <= 1'b1;
        else if (i_clr_overflow)
            o_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_wb_rsp_fifo.sv
// Directed bench for wb_rsp_fifo: single word, capacity, full push/pop, stall, wrap, overflow, reset.
module tb_wb_rsp_fifo;

    localparam int DW = 34;
    localparam int LGFLEN = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stb;
    logic [DW-1:0]   word;
    logic            busy;
    logic            clr;
    logic            o_stb;
    logic [DW-1:0]   o_word;
    logic [LGFLEN:0] o_fill;
    logic            o_full, o_almost_full, o_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_list[16];
    int sent, rcv, cyc;

    wb_rsp_fifo #(.DW(DW), .LGFLEN(LGFLEN)) dut (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_word(word), .i_busy(busy),
        .o_stb(o_stb), .o_word(o_word), .o_fill(o_fill), .o_full(o_full),
        .o_almost_full(o_almost_full), .o_overflow(o_overflow),
        .i_clr_overflow(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stb"},  64'(o_stb), 64'd0);
        chk({tag, "_word"}, 64'(o_word), 64'd0);
        chk({tag, "_fill"}, 64'(o_fill), 64'd0);
        chk({tag, "_full"}, 64'(o_full), 64'd0);
        chk({tag, "_afull"}, 64'(o_almost_full), 64'd0);
        chk({tag, "_ovf"},  64'(o_overflow), 64'd0);
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            stb = 1'b1; word = base + DW'(i);
            tick();
        end
        stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; word = '0; busy = 1'b0; clr = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk); rst = 1'b0;
        tick();

        // single word
        stb = 1'b1; word = 34'h2_DEADBEEF; busy = 1'b0;
        tick();
        stb = 1'b0;
        chk("single_stb", 64'(o_stb), 64'd1);
        chk("single_word", 64'(o_word), 64'h2_DEADBEEF);
        tick();
        chk("single_empty_stb", 64'(o_stb), 64'd0);
        chk("single_empty_fill", 64'(o_fill), 64'd0);

        // fill to capacity
        busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            stb = 1'b1; word = DW'(i);
            tick();
            chk("fill_lvl", 64'(o_fill), 64'(i + 1));
            chk("fill_afull", 64'(o_almost_full), 64'((i + 1) >= 14));
            chk("fill_full", 64'(o_full), 64'((i + 1) == 16));
        end
        word = 34'h3_FFFFFFFF;
        tick();
        stb = 1'b0;
        chk("drop_ovf", 64'(o_overflow), 64'd1);
        chk("drop_fill", 64'(o_fill), 64'd16);
        chk("drop_head", 64'(o_word), 64'd0);
        busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("drain_stb", 64'(o_stb), 64'd1);
            chk("drain_word", 64'(o_word), 64'(i));
            tick();
        end
        chk("drain_empty", 64'(o_stb), 64'd0);
        chk("drain_ovf_sticky", 64'(o_overflow), 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 64'(o_overflow), 64'd0);

        // full with simultaneous push and pop
        busy = 1'b1;
        push_n(16, 34'd100);
        chk("fpp_pre_fill", 64'(o_fill), 64'd16);
        busy = 1'b0; stb = 1'b1; word = 34'h1_12345678;
        tick();
        stb = 1'b0;
        chk("fpp_ovf", 64'(o_overflow), 64'd0);
        chk("fpp_fill", 64'(o_fill), 64'd16);
        for (int i = 0; i < 15; i++) exp_list[i] = DW'(101 + i);
        exp_list[15] = 34'h1_12345678;
        for (int i = 0; i < 16; i++) begin
            chk("fpp_word", 64'(o_word), 64'(exp_list[i]));
            tick();
        end
        chk("fpp_empty", 64'(o_stb), 64'd0);

        // backpressure stall
        busy = 1'b1;
        push_n(3, 34'h0_000000AA);
        chk("stall_w0", 64'(o_word), 64'h0AA); tick();
        chk("stall_w1", 64'(o_word), 64'h0AA); tick();
        busy = 1'b0;
        chk("stall_w2", 64'(o_word), 64'h0AA); tick();
        chk("stall_adv", 64'(o_word), 64'h0AB);
        chk("stall_fill", 64'(o_fill), 64'd2);
        tick(); tick();
        chk("stall_empty", 64'(o_stb), 64'd0);

        // wrap-around stream with random busy
        q.delete(); sent = 0; rcv = 0; cyc = 0;
        while (rcv < 40 && cyc < 2000) begin
            busy = 1'($urandom_range(0, 1));
            stb  = (sent < 40) && !o_almost_full;
            word = {2'(sent), 32'hC0DE0000 + 32'(sent)};
            if (o_stb && !busy) begin
                if (q.size() == 0) chk("wrap_extra", 64'd1, 64'd0);
                else chk("wrap_data", 64'(o_word), 64'(q.pop_front()));
                rcv++;
            end
            if (stb) begin
                q.push_back(word);
                sent++;
            end
            tick();
            cyc++;
            chk("wrap_fill", 64'(o_fill), 64'(q.size()));
            chk("wrap_max", 64'(o_fill <= 16), 64'd1);
        end
        stb = 1'b0; busy = 1'b0;
        chk("wrap_count", 64'(rcv), 64'd40);

        // overflow precedence
        busy = 1'b1;
        push_n(16, 34'd500);
        stb = 1'b1; clr = 1'b1; word = 34'h3_0BAD0BAD;
        tick();
        stb = 1'b0;
        chk("prec_ovf", 64'(o_overflow), 64'd1);
        tick(); clr = 1'b0;
        chk("prec_clr", 64'(o_overflow), 64'd0);

        // asynchronous reset mid-operation
        rst = 1'b1; tick(); rst = 1'b0; tick();
        push_n(5, 34'd900);
        chk("arst_pre_fill", 64'(o_fill), 64'd5);
        #3 rst = 1'b1;
        #1 chk_zero("arst");
        @(negedge clk); rst = 1'b0;
        busy = 1'b0; stb = 1'b1; word = 34'h2_00C0FFEE;
        tick();
        stb = 1'b0;
        chk("post_rst_stb", 64'(o_stb), 64'd1);
        chk("post_rst_word", 64'(o_word), 64'h2_00C0FFEE);
        chk("post_rst_fill", 64'(o_fill), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
